// File: rtl/sort_window_ctrl.sv
//------------------------------------------------------------------------------
// Module   : sort_window_ctrl
// Purpose  : Streaming controller for the local sorter's sliding sorted
//            window. Keeps N = WINDOW_LENGTH-1 entries in ascending order,
//            inserts each accepted element at the slot found by a single
//            insert_index datapath, emits the window minimum whenever the
//            window is full and drains the remaining entries on end-of-stream.
// Ports    : clk, rst           clock, asynchronous active-high reset
//            in_valid/in_ready  input stream handshake
//            in_data, in_last   input element and end-of-stream marker
//            out_valid/out_ready output stream handshake
//            out_data, out_last window minimum (buf[0]) and drain-final flag
//            count              occupied entries, 0..N
//            disorder_cnt       (optional) saturating count of outputs that
//                               were smaller than the previous output
// Options  : `define SORT_WINDOW_DISORDER_CNT_EN adds the disorder_cnt port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package conf_pkg;
  localparam int WINDOW_LENGTH = 4;
  localparam int DATA_W        = 8;
  typedef logic [DATA_W-1:0]                udata_t;
  typedef logic [$clog2(WINDOW_LENGTH)-1:0] window_t;
endpackage

//------------------------------------------------------------------------------
// Module   : sort_insert_index
// Purpose  : Returns the number of window entries less than or equal to the
//            key. For an ascending view this is the slot just after the last
//            equal entry, so equal keys keep arrival order.
// Ports    : i_view  N-entry ascending view, i_key new element,
//            o_index insertion slot 0..N
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module sort_insert_index
  import conf_pkg::*;
#(
  parameter int N     = 3,
  parameter int CNT_W = 2
) (
  input  udata_t           i_view [N],
  input  udata_t           i_key,
  output logic [CNT_W-1:0] o_index
);

  logic [CNT_W-1:0] w_index;

  always_comb begin
    w_index = '0;
    for (int i = 0; i < N; i++) begin
      if (i_view[i] <= i_key) begin
        w_index = w_index + 1'b1;
      end
    end
  end

  assign o_index = w_index;

endmodule

module sort_window_ctrl
  import conf_pkg::*;
#(
  parameter  int WINDOW_LENGTH = conf_pkg::WINDOW_LENGTH,
  localparam int N             = WINDOW_LENGTH - 1,
  // Holds 0..N; equals the width of window_t at the package default.
  localparam int CNT_W         = $clog2(WINDOW_LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  udata_t           in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output udata_t           out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] count
`ifdef SORT_WINDOW_DISORDER_CNT_EN
  ,
  output logic [15:0]      disorder_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_full = CNT_W'(N);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
  localparam udata_t           c_ones = '1;

  // Registered state
  state_t           r_state;
  udata_t           r_buf [N];
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic             r_out_last;

  // Combinational datapath
  logic             w_in_fire;
  logic             w_out_fire;
  udata_t           w_view [N];
  udata_t           w_ins  [N];
  logic [CNT_W-1:0] w_index;
  logic [CNT_W-1:0] w_eff_count;
  logic [CNT_W-1:0] w_pos;

  // Next-state values
  state_t           w_state_nxt;
  udata_t           w_buf_nxt [N];
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_valid_nxt;
  logic             w_last_nxt;

  // in_ready follows out_ready in STREAM so an accept there always coincides
  // with an emit, which is what keeps count from overflowing.
  assign in_ready   = (r_state == ST_FILL) || ((r_state == ST_STREAM) && out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // The view seen by insert_index: when the minimum leaves this cycle, the
  // window is viewed already shifted down with all-ones entering at the top.
  for (genvar i = 0; i < N; i++) begin : g_view
    if (i == N - 1) begin : g_top
      assign w_view[i] = w_out_fire ? c_ones : r_buf[i];
    end else begin : g_mid
      assign w_view[i] = w_out_fire ? r_buf[i+1] : r_buf[i];
    end
  end

  sort_insert_index #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_insert_index (
    .i_view  (w_view),
    .i_key   (in_data),
    .o_index (w_index)
  );

  // Clamping to the occupied count keeps an all-ones element from landing
  // inside the all-ones padding above it, which would break the tie order.
  assign w_eff_count = w_out_fire ? (r_count - 1'b1) : r_count;
  assign w_pos       = (w_index < w_eff_count) ? w_index : w_eff_count;

  // Shift-up insert: entries below pos stay, in_data at pos, the rest move up.
  for (genvar i = 0; i < N; i++) begin : g_ins
    if (i == 0) begin : g_bottom
      assign w_ins[i] = (w_pos == '0) ? in_data : w_view[0];
    end else begin : g_upper
      assign w_ins[i] = (CNT_W'(i) < w_pos)  ? w_view[i] :
                        (CNT_W'(i) == w_pos) ? in_data   : w_view[i-1];
    end
  end

  always_comb begin
    w_buf_nxt   = r_buf;
    w_count_nxt = r_count;
    w_state_nxt = r_state;

    if (w_in_fire) begin
      w_buf_nxt   = w_ins;
      w_count_nxt = w_eff_count + 1'b1;
    end else if (w_out_fire) begin
      w_buf_nxt   = w_view;
      w_count_nxt = r_count - 1'b1;
    end

    case (r_state)
      ST_FILL: begin
        if (w_in_fire) begin
          if (in_last) begin
            w_state_nxt = ST_DRAIN;
          end else if (w_count_nxt == c_full) begin
            w_state_nxt = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (w_in_fire && in_last) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_count_nxt != c_full) begin
          // An emit with no accompanying input shrinks the window.
          w_state_nxt = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (w_out_fire && (r_count == c_one)) begin
          w_state_nxt = ST_FILL;
          w_count_nxt = '0;
          for (int i = 0; i < N; i++) begin
            w_buf_nxt[i] = c_ones;
          end
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase

    w_valid_nxt = (w_state_nxt == ST_STREAM) ||
                  ((w_state_nxt == ST_DRAIN) && (w_count_nxt != '0));
    w_last_nxt  = (w_state_nxt == ST_DRAIN) && (w_count_nxt == c_one);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= c_ones;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_last  <= w_last_nxt;
      r_buf       <= w_buf_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_buf[0];
  assign count     = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_in_fire && (r_count == c_full) && !w_out_fire));

`ifdef SORT_WINDOW_DISORDER_CNT_EN
  udata_t      r_prev;
  logic        r_prev_vld;
  logic [15:0] r_disorder_cnt;

  // Compares each emitted value with the previous one of the same stream;
  // the history is forgotten after the drain's final element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev         <= '0;
      r_prev_vld     <= 1'b0;
      r_disorder_cnt <= '0;
    end else if (w_out_fire) begin
      if (r_prev_vld && (r_buf[0] < r_prev) && (r_disorder_cnt != 16'hFFFF)) begin
        r_disorder_cnt <= r_disorder_cnt + 16'd1;
      end
      r_prev     <= r_buf[0];
      r_prev_vld <= !r_out_last;
    end
  end

  assign disorder_cnt = r_disorder_cnt;
`endif

endmodule

`default_nettype wire
